spi_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one SPI master between two requesters
//  (e.g. inertial-sensor and A2D interfaces). Grants one requester at a time,

---
 rtl/spi_arb.sv | 117 +++++++++++
 tb/tb_spi_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Launches the granted command, waits for done (with watchdog), acks, then idles for a fixed gap.
module spi_arb #(
   parameter int unsigned GAP_CYC     = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] cmd0,
   input  logic        req1,
   input  logic [15:0] cmd1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] rd_data,
   output logic        err,
   output logic        busy,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DONE,
      GAP
   } state_t;

   state_t        state;
   logic          prio;
   logic          owner;
   logic          done_q;
   logic [TW-1:0] timer;
   logic [GW-1:0] gap_cnt;
   logic          winner;
   logic          done_rise;

   always_comb begin
      winner    = (req0 & req1) ? prio : req1;
      // only a fresh rising edge completes; a level left over from the last transfer is ignored
      done_rise = spi_done & ~done_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         prio    <= 1'b0;
         owner   <= 1'b0;
         done_q  <= 1'b0;
         timer   <= '0;
         gap_cnt <= '0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         spi_wrt <= 1'b0;
         spi_cmd <= '0;
         rd_data <= '0;
      end else begin
         done_q  <= spi_done;
         spi_wrt <= 1'b0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  spi_wrt <= 1'b1;
                  spi_cmd <= winner ? cmd1 : cmd0;
                  owner   <= winner;
                  prio    <= ~winner;
                  timer   <= '0;
                  state   <= WAIT_DONE;
                  busy    <= 1'b1;
               end
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  rd_data <= spi_rd_data;
                  ack0    <= ~owner;
                  ack1    <= owner;
                  gap_cnt <= '0;
                  state   <= GAP;
               end else if (timer == T_LAST) begin
                  ack0    <= ~owner;
                  ack1    <= owner;
                  err     <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            GAP: begin
               // the ack cycle is the first gap cycle
               if (gap_cnt == G_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: a timestamp-based transaction model checked every cycle,
// plus hand-computed latency and value expectations per scenario.
module tb_spi_arb;

   localparam int GAP = 4;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, spi_done = 1'b0;
   logic [15:0] cmd0 = '0, cmd1 = '0, spi_rd_data = '0;
   logic        ack0, ack1, err, busy, spi_wrt;
   logic [15:0] rd_data, spi_cmd;

   spi_arb #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
      .ack0(ack0), .ack1(ack1), .rd_data(rd_data), .err(err), .busy(busy),
      .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
      .spi_done(spi_done), .spi_rd_data(spi_rd_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // model: launch/ack timestamps instead of states
   int          m_cyc, m_free, m_launch;
   bit          m_fly, m_owner, m_prio, m_prev;
   logic        m_ack0, m_ack1, m_err, m_busy, m_wrt;
   logic [15:0] m_cmd, m_rd;

   always @(posedge clk or negedge rst_n) begin
      int c;
      bit w;
      if (!rst_n) begin
         m_cyc = 0; m_free = 0; m_launch = 0;
         m_fly = 0; m_owner = 0; m_prio = 0; m_prev = 0;
         m_ack0 = 0; m_ack1 = 0; m_err = 0; m_busy = 0; m_wrt = 0;
         m_cmd = '0; m_rd = '0;
      end else begin
         c = m_cyc;
         m_cyc = c + 1;
         m_wrt = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0;
         if (m_fly) begin
            if ((spi_done && !m_prev) || (c - m_launch == TMO - 1)) begin
               m_err = !(spi_done && !m_prev);
               if (!m_err) m_rd = spi_rd_data;
               m_ack0 = !m_owner;
               m_ack1 = m_owner;
               m_fly  = 0;
               m_free = c + 1 + GAP;
            end
         end else if (c >= m_free && (req0 || req1)) begin
            w = (req0 && req1) ? m_prio : req1;
            m_wrt = 1;
            m_cmd = w ? cmd1 : cmd0;
            m_owner = w;
            m_prio = !w;
            m_fly = 1;
            m_launch = c + 1;
         end
         m_busy = m_fly || (c + 1 < m_free);
         m_prev = spi_done;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if ({ack0, ack1, err, busy, spi_wrt, spi_cmd, rd_data} !==
             {m_ack0, m_ack1, m_err, m_busy, m_wrt, m_cmd, m_rd}) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got ack=%b%b err=%b busy=%b wrt=%b cmd=%h rd=%h exp ack=%b%b err=%b busy=%b wrt=%b cmd=%h rd=%h",
                     $time, ack0, ack1, err, busy, spi_wrt, spi_cmd, rd_data,
                     m_ack0, m_ack1, m_err, m_busy, m_wrt, m_cmd, m_rd);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   int waited;
   task automatic wait_wrt(input int maxc);
      waited = 0;
      while (!spi_wrt && waited < maxc) begin
         tick;
         waited++;
      end
      if (!spi_wrt) chk("wrt_timeout", 64'(spi_wrt), 64'd1);
   endtask

   initial begin
      int n;
      int acks;
      #1;
      do_reset;
      chk("reset_outs", 64'({ack0, ack1, err, busy, spi_wrt, spi_cmd, rd_data}), 64'd0);

      // 1: single transaction, done 40 clks after wrt
      cmd0 = 16'h8F00; req0 = 1'b1;
      tick;
      chk("t1_wrt_lat", 64'(spi_wrt), 64'd1);
      chk("t1_cmd", 64'(spi_cmd), 64'h8F00);
      repeat (40) tick;
      chk("t1_no_early_ack", 64'(ack0), 64'd0);
      spi_done = 1'b1; spi_rd_data = 16'h006A;
      tick;
      chk("t1_ack0", 64'({ack0, ack1, err}), 64'b100);
      chk("t1_rd", 64'(rd_data), 64'h006A);
      tick;
      req0 = 1'b0; spi_done = 1'b0;
      repeat (GAP + 2) tick;

      // 2: both held high after reset -> 0,1,0,1
      do_reset;
      cmd0 = 16'hA000; cmd1 = 16'hB001; req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_wrt(20);
         chk("t2_grant", 64'(spi_cmd), (k % 2) ? 64'hB001 : 64'hA000);
         repeat (3) tick;
         spi_done = 1'b1; spi_rd_data = 16'h1000 + 16'(k);
         tick;
         chk("t2_ack", 64'({ack0, ack1}), (k % 2) ? 64'b01 : 64'b10);
         spi_done = 1'b0;
         tick;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (GAP + 2) tick;

      // 3: stale done level ignored, second rise completes
      spi_done = 1'b1;
      tick;
      cmd1 = 16'hC0DE; req1 = 1'b1;
      wait_wrt(10);
      repeat (3) tick;
      spi_done = 1'b0;
      tick;
      tick;
      chk("t3_no_ack", 64'(ack1), 64'd0);
      spi_done = 1'b1; spi_rd_data = 16'h55AA;
      tick;
      chk("t3_ack", 64'({ack1, err}), 64'b10);
      chk("t3_rd", 64'(rd_data), 64'h55AA);
      tick;
      req1 = 1'b0;
      repeat (GAP + 2) tick;
      spi_done = 1'b0;
      tick;

      // 4: watchdog, then the pending request proceeds
      cmd1 = 16'h4444; req1 = 1'b1;
      wait_wrt(10);
      cmd0 = 16'h1234; req0 = 1'b1;
      n = 0;
      while (!ack1 && n < 100) begin
         tick;
         n++;
      end
      chk("t4_timeout_lat", 64'(n), 64'd64);
      chk("t4_err", 64'({ack1, err}), 64'b11);
      chk("t4_rd_kept", 64'(rd_data), 64'h55AA);
      tick;
      req1 = 1'b0;
      wait_wrt(20);
      chk("t4_next_grant", 64'(spi_cmd), 64'h1234);
      repeat (2) tick;
      spi_done = 1'b1; spi_rd_data = 16'h0777;
      tick;
      chk("t4_ack0", 64'({ack0, err}), 64'b10);
      tick;
      req0 = 1'b0; spi_done = 1'b0;
      repeat (GAP + 2) tick;

      // 5: req1 pending during req0 service -> wrt 5 clks after ack0
      cmd0 = 16'h5A5A; req0 = 1'b1;
      wait_wrt(10);
      cmd1 = 16'hA5A5; req1 = 1'b1;
      repeat (2) tick;
      spi_done = 1'b1; spi_rd_data = 16'h0BEE;
      tick;
      chk("t5_ack0", 64'(ack0), 64'd1);
      n = 0;
      while (!spi_wrt && n < 20) begin
         tick;
         n++;
         if (n == 1) begin req0 = 1'b0; spi_done = 1'b0; end
      end
      chk("t5_gap", 64'(n), 64'd5);
      chk("t5_cmd", 64'(spi_cmd), 64'hA5A5);
      repeat (2) tick;
      spi_done = 1'b1; spi_rd_data = 16'h0C0C;
      tick;
      chk("t5_ack1", 64'(ack1), 64'd1);
      tick;
      req1 = 1'b0; spi_done = 1'b0;
      repeat (GAP + 2) tick;

      // 6: reset mid-WAIT_DONE
      cmd0 = 16'h6666; req0 = 1'b1;
      wait_wrt(10);
      repeat (3) tick;
      rst_n = 1'b0;
      #1;
      chk("t6_async_clear", 64'({ack0, ack1, err, busy, spi_wrt, spi_cmd, rd_data}), 64'd0);
      req0 = 1'b0; spi_done = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
      acks = 0;
      for (int k = 0; k < 10; k++) begin
         tick;
         acks += int'(ack0) + int'(ack1) + int'(err) + int'(busy);
      end
      chk("t6_quiet", 64'(acks), 64'd0);
      cmd0 = 16'h0101; cmd1 = 16'h0202; req0 = 1'b1; req1 = 1'b1;
      wait_wrt(10);
      chk("t6_prio_reset", 64'(spi_cmd), 64'h0101);
      tick;
      spi_done = 1'b1; spi_rd_data = 16'h7E7E;
      tick;
      chk("t6_ack0", 64'(ack0), 64'd1);
      tick;
      req0 = 1'b0; req1 = 1'b0; spi_done = 1'b0;
      repeat (GAP + 2) tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
